// File: rtl/systemverilog_bus_mux.sv
// Bus-to-stream serializer: one bus write {adr, dat} becomes PKT_N stream bytes,
// least significant byte first, so the far-end demux rebuilds the same write.
// Optional feature: define SYSTEMVERILOG_BUS_MUX_PREFETCH_EN to add a one-entry
// holding register so the next packet can be accepted while one is still sending.
module systemverilog_bus_mux #(
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_vld,
  input  logic [ADR_W-1:0] bus_adr,
  input  logic [DAT_W-1:0] bus_dat,
  output logic             bus_rdy,
  output logic             str_vld,
  output logic [7:0]       str_bus,
  input  logic             str_rdy
);

  localparam int unsigned PKT_W = ADR_W + DAT_W;
  localparam int unsigned PKT_N = PKT_W / 8;
  localparam int unsigned CNT_W = (PKT_N > 1) ? $clog2(PKT_N) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_rdy_q, bus_rdy_d;
  logic               str_vld_q, str_vld_d;
  logic [PKT_W-1:0]   pkt;
  logic               bus_trn, str_trn, last;
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
  logic [PKT_W-1:0]   hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
`endif

  assign pkt     = {bus_adr, bus_dat};
  assign bus_trn = bus_vld & bus_rdy_q;
  assign str_trn = str_vld_q & str_rdy;
  assign last    = (cnt_q == CNT_W'(PKT_N - 1));

  // Current byte is always the low byte of the shift register.
  assign bus_rdy = bus_rdy_q;
  assign str_vld = str_vld_q;
  assign str_bus = sreg_q[7:0];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      cnt_q      <= '0;
      bus_rdy_q  <= 1'b1;
      str_vld_q  <= 1'b0;
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      bus_rdy_q  <= bus_rdy_d;
      str_vld_q  <= str_vld_d;
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  // Next-state: leave SEND only after the last byte with nothing queued behind it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus_trn) state_d = StSend;
      StSend: begin
        if (str_trn && last) begin
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
          if (!hold_vld_q && !bus_trn) state_d = StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values for the shift register, counter, holding slot and registered outputs.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    if (state_q == StIdle) begin
      if (bus_trn) begin
        sreg_d = pkt;
        cnt_d  = '0;
      end
    end else begin
      if (str_trn) begin
        if (!last) begin
          sreg_d = sreg_q >> 8;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          sreg_d = sreg_q >> 8;
          cnt_d  = '0;
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
          // Reload without a bubble: queued packet first, else a coinciding write.
          if (hold_vld_q) begin
            sreg_d     = hold_q;
            hold_vld_d = bus_trn;
            if (bus_trn) hold_d = pkt;
          end else if (bus_trn) begin
            sreg_d = pkt;
          end
`endif
        end
      end
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
      if (bus_trn && !(str_trn && last)) begin
        hold_d     = pkt;
        hold_vld_d = 1'b1;
      end
`endif
    end
    str_vld_d = (state_d == StSend);
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
    bus_rdy_d = !hold_vld_d;
`else
    bus_rdy_d = (state_d == StIdle);
`endif
  end

endmodule

// File: tb/tb_systemverilog_bus_mux.sv
// Self-checking bench for systemverilog_bus_mux: directed scenarios plus random
// traffic, checked against a byte-queue model of outstanding packet bytes.
module tb_systemverilog_bus_mux;

  localparam int PKT_N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_vld;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
  logic        bus_rdy;
  logic        str_vld;
  logic [7:0]  str_bus;
  logic        str_rdy;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  q[$];    // bytes accepted from the bus but not yet taken by the stream
  logic [7:0]  acc[$];  // bytes taken by the stream, in order

  systemverilog_bus_mux dut (
    .clk     (clk),
    .rst     (rst),
    .bus_vld (bus_vld),
    .bus_adr (bus_adr),
    .bus_dat (bus_dat),
    .bus_rdy (bus_rdy),
    .str_vld (str_vld),
    .str_bus (str_bus),
    .str_rdy (str_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record transfers seen before the edge, update the model, compare after.
  task automatic cycle();
    logic        bt, st, stall;
    logic [63:0] pkt;
    logic [7:0]  prev_byte;
    bt        = bus_vld && bus_rdy;
    st        = str_vld && str_rdy;
    stall     = str_vld && !str_rdy;
    prev_byte = str_bus;
    pkt       = {bus_adr, bus_dat};
    if (st && !rst) acc.push_back(str_bus);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (st && q.size() > 0) void'(q.pop_front());
      if (bt) for (int i = 0; i < PKT_N; i++) q.push_back(pkt[8*i +: 8]);
    end
    check("str_vld", {63'd0, str_vld}, {63'd0, q.size() > 0});
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
    check("bus_rdy", {63'd0, bus_rdy}, {63'd0, q.size() <= PKT_N});
`else
    check("bus_rdy", {63'd0, bus_rdy}, {63'd0, q.size() == 0});
`endif
    if (q.size() > 0) check("str_bus", {56'd0, str_bus}, {56'd0, q[0]});
    if (stall && !rst) check("stall_hold", {55'd0, str_vld, str_bus}, {55'd0, 1'b1, prev_byte});
  endtask

  task automatic check_seq(input string tag, input int base, input logic [63:0] exp);
    for (int i = 0; i < PKT_N; i++) begin
      if (acc.size() > base + i) check(tag, {56'd0, acc[base+i]}, {56'd0, exp[8*i +: 8]});
      else check(tag, 64'(acc.size()), 64'(base + i + 1));
    end
  endtask

  initial begin
    logic [63:0] p1, p2;
    logic        ack;
    int          sent, gaps;
    logic [3:0]  pat;
    p1  = {32'h1122_3344, 32'h5566_7788};
    p2  = {32'h0000_00A0, 32'h0000_00B1};
    pat = 4'b1001;  // str_rdy sequence 1,0,0,1 (bit 0 first)

    // Reset values
    rst = 1'b1; bus_vld = 1'b0; bus_adr = '0; bus_dat = '0; str_rdy = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_bus_rdy", {63'd0, bus_rdy}, 64'd1);
    check("rst_str_vld", {63'd0, str_vld}, 64'd0);
    check("rst_str_bus", {56'd0, str_bus}, 64'd0);

    // Single packet, stream always ready
    acc.delete();
    bus_adr = p1[63:32]; bus_dat = p1[31:0]; bus_vld = 1'b1; str_rdy = 1'b1;
    cycle();
    bus_vld = 1'b0;
    check("lat_byte0", {56'd0, str_bus}, 64'h88);
    repeat (PKT_N) cycle();
    check_seq("seq_basic", 0, p1);
    check("lat_bus_rdy", {63'd0, bus_rdy}, 64'd1);

    // Same packet with str_rdy toggling
    acc.delete();
    bus_vld = 1'b1;
    cycle();
    bus_vld = 1'b0;
    for (int k = 0; k < 60 && acc.size() < PKT_N; k++) begin
      str_rdy = pat[k % 4];
      cycle();
    end
    check_seq("seq_toggle", 0, p1);
    str_rdy = 1'b1;
    repeat (3) cycle();
    check("toggle_no_dup", 64'(acc.size()), 64'(PKT_N));

    // Second request held high during SEND
    acc.delete();
    bus_adr = p1[63:32]; bus_dat = p1[31:0]; bus_vld = 1'b1; str_rdy = 1'b1;
    sent = 0; gaps = 0;
    for (int k = 0; k < 60 && acc.size() < 2 * PKT_N; k++) begin
      ack = bus_vld && bus_rdy;
      cycle();
      if (ack) begin
        if (sent == 0) begin bus_adr = p2[63:32]; bus_dat = p2[31:0]; end
        else bus_vld = 1'b0;
        sent++;
      end
      if (acc.size() > 0 && acc.size() < 2 * PKT_N && !str_vld) gaps++;
    end
    bus_vld = 1'b0;
    check_seq("seq_first", 0, p1);
    check_seq("seq_second", PKT_N, p2);
`ifdef SYSTEMVERILOG_BUS_MUX_PREFETCH_EN
    check("prefetch_gaps", 64'(gaps), 64'd0);
`endif
    repeat (2) cycle();

    // Reset after three bytes
    acc.delete();
    bus_adr = p1[63:32]; bus_dat = p1[31:0]; bus_vld = 1'b1; str_rdy = 1'b1;
    cycle();
    bus_vld = 1'b0;
    for (int k = 0; k < 20 && acc.size() < 3; k++) cycle();
    str_rdy = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_str_vld", {63'd0, str_vld}, 64'd0);
    check("mid_rst_bus_rdy", {63'd0, bus_rdy}, 64'd1);
    acc.delete();
    bus_vld = 1'b1; str_rdy = 1'b1;
    cycle();
    bus_vld = 1'b0;
    for (int k = 0; k < 20 && acc.size() < PKT_N; k++) cycle();
    check_seq("seq_after_rst", 0, p1);

    // Long stall with byte 0 pending
    repeat (2) cycle();
    str_rdy = 1'b0; bus_vld = 1'b1;
    cycle();
    bus_vld = 1'b0;
    repeat (20) cycle();
    check("stall_byte0", {56'd0, str_bus}, 64'h88);
    str_rdy = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) cycle();

    // Random traffic; the master holds each request until acknowledged
    bus_vld = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!bus_vld && $urandom_range(0, 2) == 0) begin
        bus_vld = 1'b1; bus_adr = $urandom; bus_dat = $urandom;
      end
      str_rdy = ($urandom_range(0, 3) != 0);
      ack = bus_vld && bus_rdy;
      cycle();
      if (ack) bus_vld = 1'b0;
    end
    bus_vld = 1'b0; str_rdy = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
